// File: rtl/pc_next_reg.sv
// rtl/pc_next_reg.sv - fetch-stage program counter with next-address selection, trap redirect and misalign fault
module pc_next_reg #(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
    parameter int                IALIGN       = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic [1:0]      sel,
    input  logic [XLEN-1:0] br_target,
    input  logic [XLEN-1:0] jal_target,
    input  logic [XLEN-1:0] jalr_target,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            redirect,
    output logic            misalign,
    output logic [XLEN-1:0] misalign_addr
);

    // Number of low target bits that must be zero for a legal fetch address.
    localparam int ALIGN_BITS = (IALIGN == 2) ? 1 : 2;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [XLEN-1:0] target;
    logic            bad;
    logic [XLEN-1:0] next_pc;
    logic            next_redirect;
    logic            next_misalign;
    logic [XLEN-1:0] next_misalign_addr;

    // Sequential address; the carry out of the top bit is dropped so the PC wraps.
    assign pc_plus4 = pc + XLEN'(4);

    // Candidate next address; the JALR sum has bit 0 forced low before use.
    always_comb begin
        target = pc_plus4;
        case (sel)
            2'b00:   target = pc_plus4;
            2'b01:   target = br_target;
            2'b10:   target = jal_target;
            default: target = jalr_target & ~XLEN'(1);
        endcase
    end

    // Only non-sequential targets can be misaligned; PC+4 inherits the current PC's alignment.
    assign bad = (sel != 2'b00) && (target[ALIGN_BITS-1:0] != '0);

    // Next-state and next-register values; redirect/misalign default to no pulse.
    always_comb begin
        next_state         = state;
        next_pc            = pc;
        next_redirect      = 1'b0;
        next_misalign      = 1'b0;
        next_misalign_addr = misalign_addr;
        case (state)
            RUN: begin
                if (trap_req) begin
                    next_pc       = trap_vector;
                    next_redirect = 1'b1;
                end else if (stall) begin
                    next_pc = pc;
                end else if (bad) begin
                    next_misalign      = 1'b1;
                    next_misalign_addr = target;
                    next_state         = FAULT;
                end else begin
                    next_pc       = target;
                    next_redirect = (sel != 2'b00);
                end
            end
            FAULT: begin
                // Single-cycle exit into the trap handler; stall, sel and trap_req are ignored here.
                next_pc       = trap_vector;
                next_redirect = 1'b1;
                next_state    = RUN;
            end
            default: begin
                next_state = RUN;
            end
        endcase
    end

    // State and output registers; reset overrides everything including a pending FAULT exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            pc            <= RESET_VECTOR;
            redirect      <= 1'b0;
            misalign      <= 1'b0;
            misalign_addr <= '0;
        end else begin
            state         <= next_state;
            pc            <= next_pc;
            redirect      <= next_redirect;
            misalign      <= next_misalign;
            misalign_addr <= next_misalign_addr;
        end
    end

endmodule

// File: tb/tb_pc_next_reg.sv
// tb/tb_pc_next_reg.sv - self-checking bench for pc_next_reg with IALIGN=4 and IALIGN=2 instances
module tb_pc_next_reg;

    localparam logic [31:0] RV = 32'h100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic [1:0]  sel = 2'b00;
    logic [31:0] br_target = '0;
    logic [31:0] jal_target = '0;
    logic [31:0] jalr_target = '0;
    logic        trap_req = 1'b0;
    logic [31:0] trap_vector = '0;

    logic [31:0] pc4, pp4_4, ma4;
    logic        rd4, mi4;
    logic [31:0] pc2, pp4_2, ma2;
    logic        rd2, mi2;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state, index 0 = IALIGN 4, index 1 = IALIGN 2
    logic [31:0] m_pc [2];
    logic        m_red [2];
    logic        m_mis [2];
    logic [31:0] m_addr [2];
    logic        m_fault [2];
    int unsigned ia [2] = '{4, 2};

    always #5 clk = ~clk;

    pc_next_reg #(.XLEN(32), .RESET_VECTOR(RV), .IALIGN(4)) dut4 (
        .clk(clk), .rst(rst), .stall(stall), .sel(sel),
        .br_target(br_target), .jal_target(jal_target), .jalr_target(jalr_target),
        .trap_req(trap_req), .trap_vector(trap_vector),
        .pc(pc4), .pc_plus4(pp4_4), .redirect(rd4), .misalign(mi4), .misalign_addr(ma4)
    );

    pc_next_reg #(.XLEN(32), .RESET_VECTOR(RV), .IALIGN(2)) dut2 (
        .clk(clk), .rst(rst), .stall(stall), .sel(sel),
        .br_target(br_target), .jal_target(jal_target), .jalr_target(jalr_target),
        .trap_req(trap_req), .trap_vector(trap_vector),
        .pc(pc2), .pc_plus4(pp4_2), .redirect(rd2), .misalign(mi2), .misalign_addr(ma2)
    );

    // Model of one clock edge, written from the priority rules with plain arithmetic.
    task automatic model_edge();
        logic [31:0] t;
        logic        bad;
        for (int k = 0; k < 2; k++) begin
            case (sel)
                2'd0: t = m_pc[k] + 32'd4;
                2'd1: t = br_target;
                2'd2: t = jal_target;
                default: t = jalr_target - (jalr_target % 2);
            endcase
            bad = (sel != 2'd0) && ((t % ia[k]) != 0);
            if (rst) begin
                m_pc[k] = RV; m_red[k] = 0; m_mis[k] = 0; m_addr[k] = 0; m_fault[k] = 0;
            end else if (m_fault[k]) begin
                m_pc[k] = trap_vector; m_red[k] = 1; m_mis[k] = 0; m_fault[k] = 0;
            end else if (trap_req) begin
                m_pc[k] = trap_vector; m_red[k] = 1; m_mis[k] = 0;
            end else if (stall) begin
                m_red[k] = 0; m_mis[k] = 0;
            end else if (bad) begin
                m_mis[k] = 1; m_addr[k] = t; m_red[k] = 0; m_fault[k] = 1;
            end else begin
                m_pc[k] = t; m_red[k] = (sel != 2'd0); m_mis[k] = 0;
            end
        end
    endtask

    // Advance one clock with the current inputs held, then settle for sampling.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic r, input logic s, input logic [1:0] sl,
                         input logic tr, input logic [31:0] tv);
        rst = r; stall = s; sel = sl; trap_req = tr; trap_vector = tv;
    endtask

    task automatic test_reset();
        drive(1, 0, 2'd0, 0, 32'h0);
        step(); step();
        n_cmp++; if (pc4 !== RV) begin n_bad++; $display("FAIL reset_pc got %h exp %h", pc4, RV); end
        n_cmp++; if (rd4 !== 1'b0 || mi4 !== 1'b0) begin n_bad++; $display("FAIL reset_flags got %b%b exp 00", rd4, mi4); end
        n_cmp++; if (ma4 !== 32'h0) begin n_bad++; $display("FAIL reset_addr got %h exp 0", ma4); end
        drive(0, 0, 2'd0, 0, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            step();
            n_cmp++; if (pc4 !== RV + 32'(4 * i)) begin n_bad++; $display("FAIL run_pc%0d got %h exp %h", i, pc4, RV + 32'(4 * i)); end
            n_cmp++; if (rd4 !== 1'b0) begin n_bad++; $display("FAIL run_redirect%0d got %b exp 0", i, rd4); end
        end
    endtask

    task automatic test_jalr();
        drive(0, 0, 2'd0, 1, 32'h200);
        step();
        n_cmp++; if (pc4 !== 32'h200 || rd4 !== 1'b1) begin n_bad++; $display("FAIL trap_to_200 got %h/%b exp 200/1", pc4, rd4); end
        jalr_target = 32'h3001;
        drive(0, 0, 2'd3, 0, 32'h0);
        step();
        n_cmp++; if (pc4 !== 32'h3000) begin n_bad++; $display("FAIL jalr_pc got %h exp 3000", pc4); end
        n_cmp++; if (rd4 !== 1'b1 || mi4 !== 1'b0) begin n_bad++; $display("FAIL jalr_flags got %b%b exp 10", rd4, mi4); end
        n_cmp++; if (pc2 !== 32'h3000) begin n_bad++; $display("FAIL jalr_pc_ia2 got %h exp 3000", pc2); end
        drive(0, 0, 2'd0, 0, 32'h0);
        step();
        n_cmp++; if (pc4 !== 32'h3004 || rd4 !== 1'b0) begin n_bad++; $display("FAIL jalr_after got %h/%b exp 3004/0", pc4, rd4); end
    endtask

    task automatic test_stall_trap();
        logic [31:0] held;
        held = pc4;
        br_target = 32'h400;
        drive(0, 1, 2'd1, 0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++; if (pc4 !== held || rd4 !== 1'b0) begin n_bad++; $display("FAIL stall_hold%0d got %h/%b exp %h/0", i, pc4, rd4, held); end
        end
        drive(0, 1, 2'd1, 1, 32'h80);
        step();
        n_cmp++; if (pc4 !== 32'h80 || rd4 !== 1'b1) begin n_bad++; $display("FAIL stall_trap got %h/%b exp 80/1", pc4, rd4); end
    endtask

    task automatic test_misalign();
        drive(0, 0, 2'd0, 1, 32'h500);
        step();
        br_target = 32'h602;
        drive(0, 0, 2'd1, 0, 32'h40);
        step();
        n_cmp++; if (pc4 !== 32'h500 || mi4 !== 1'b1 || rd4 !== 1'b0) begin n_bad++; $display("FAIL mis_c1 got %h/%b/%b exp 500/1/0", pc4, mi4, rd4); end
        n_cmp++; if (ma4 !== 32'h602) begin n_bad++; $display("FAIL mis_addr got %h exp 602", ma4); end
        n_cmp++; if (pc2 !== 32'h602 || mi2 !== 1'b0 || rd2 !== 1'b1) begin n_bad++; $display("FAIL mis_ia2 got %h/%b/%b exp 602/0/1", pc2, mi2, rd2); end
        drive(0, 1, 2'd2, 0, 32'h40);
        step();
        n_cmp++; if (pc4 !== 32'h40 || rd4 !== 1'b1 || mi4 !== 1'b0) begin n_bad++; $display("FAIL mis_c2 got %h/%b/%b exp 40/1/0", pc4, rd4, mi4); end
        n_cmp++; if (ma4 !== 32'h602) begin n_bad++; $display("FAIL mis_addr_hold got %h exp 602", ma4); end
        drive(0, 0, 2'd0, 0, 32'h0);
        step();
        n_cmp++; if (pc4 !== 32'h44 || rd4 !== 1'b0) begin n_bad++; $display("FAIL mis_after got %h/%b exp 44/0", pc4, rd4); end
    endtask

    task automatic test_wrap();
        drive(0, 0, 2'd0, 1, 32'hFFFF_FFFC);
        step();
        n_cmp++; if (pp4_4 !== 32'h0) begin n_bad++; $display("FAIL wrap_plus4 got %h exp 0", pp4_4); end
        drive(0, 0, 2'd0, 0, 32'h0);
        step();
        n_cmp++; if (pc4 !== 32'h0 || rd4 !== 1'b0) begin n_bad++; $display("FAIL wrap_pc got %h/%b exp 0/0", pc4, rd4); end
    endtask

    task automatic test_reset_fault();
        drive(0, 0, 2'd0, 1, 32'h500);
        step();
        br_target = 32'h603;
        drive(0, 0, 2'd1, 0, 32'h40);
        step();
        n_cmp++; if (mi4 !== 1'b1) begin n_bad++; $display("FAIL rf_fault got %b exp 1", mi4); end
        drive(1, 0, 2'd0, 0, 32'h40);
        step();
        n_cmp++; if (pc4 !== RV || rd4 !== 1'b0 || mi4 !== 1'b0 || ma4 !== 32'h0) begin n_bad++; $display("FAIL rf_reset got %h/%b/%b/%h exp %h/0/0/0", pc4, rd4, mi4, ma4, RV); end
        drive(0, 0, 2'd0, 0, 32'h40);
        step();
        n_cmp++; if (pc4 !== RV + 32'd4 || rd4 !== 1'b0) begin n_bad++; $display("FAIL rf_run got %h/%b exp %h/0", pc4, rd4, RV + 32'd4); end
    endtask

    task automatic test_back_to_back();
        drive(0, 0, 2'd0, 1, 32'h1000);
        step();
        n_cmp++; if (pc4 !== 32'h1000 || rd4 !== 1'b1) begin n_bad++; $display("FAIL b2b_trap got %h/%b exp 1000/1", pc4, rd4); end
        br_target = 32'h2000;
        drive(0, 0, 2'd1, 0, 32'h0);
        step();
        n_cmp++; if (pc4 !== 32'h2000 || rd4 !== 1'b1) begin n_bad++; $display("FAIL b2b_branch got %h/%b exp 2000/1", pc4, rd4); end
    endtask

    task automatic test_random();
        logic [31:0] o_pc, o_pp, o_ma;
        logic        o_rd, o_mi;
        for (int c = 0; c < 600; c++) begin
            rst         = ($urandom_range(0, 39) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            trap_req    = ($urandom_range(0, 7) == 0);
            sel         = 2'($urandom_range(0, 3));
            br_target   = $urandom;
            jal_target  = $urandom;
            jalr_target = $urandom;
            trap_vector = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 1) == 0) begin
                br_target[1:0]  = 2'b00;
                jal_target[1:0] = 2'b00;
            end
            step();
            for (int k = 0; k < 2; k++) begin
                o_pc = k == 0 ? pc4 : pc2;
                o_pp = k == 0 ? pp4_4 : pp4_2;
                o_ma = k == 0 ? ma4 : ma2;
                o_rd = k == 0 ? rd4 : rd2;
                o_mi = k == 0 ? mi4 : mi2;
                n_cmp++; if (o_pc !== m_pc[k]) begin n_bad++; $display("FAIL rnd_pc ia%0d c%0d got %h exp %h", ia[k], c, o_pc, m_pc[k]); end
                n_cmp++; if (o_pp !== m_pc[k] + 32'd4) begin n_bad++; $display("FAIL rnd_plus4 ia%0d c%0d got %h exp %h", ia[k], c, o_pp, m_pc[k] + 32'd4); end
                n_cmp++; if (o_rd !== m_red[k]) begin n_bad++; $display("FAIL rnd_redirect ia%0d c%0d got %b exp %b", ia[k], c, o_rd, m_red[k]); end
                n_cmp++; if (o_mi !== m_mis[k]) begin n_bad++; $display("FAIL rnd_misalign ia%0d c%0d got %b exp %b", ia[k], c, o_mi, m_mis[k]); end
                n_cmp++; if (o_ma !== m_addr[k]) begin n_bad++; $display("FAIL rnd_addr ia%0d c%0d got %h exp %h", ia[k], c, o_ma, m_addr[k]); end
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_jalr();
        test_stall_trap();
        test_misalign();
        test_wrap();
        test_reset_fault();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_next_reg.md
# pc_next_reg

Program-counter register with next-address selection for the processor fetch stage. It is the parametrised successor of the combinational four-input PC-source multiplexer. It picks the next PC from the sequential, branch, JAL or JALR source, and clears bit 0 of the JALR target. It adds stall hold, trap redirection, misaligned-target detection with a one-cycle fault state, and a registered redirect pulse that drives pipeline flush.

## Interface
Parameters:
- XLEN, 32, address/PC width (≥ 8)
- RESET_VECTOR, {XLEN{1'b0}}, PC value loaded on reset
- IALIGN, 4, instruction alignment in bytes; legal values 2 or 4

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold PC (fetch back-pressure)
- sel  in  2  source: 00 PC+4, 01 br_target, 10 jal_target, 11 jalr_target
- br_target  in  XLEN  branch target address
- jal_target  in  XLEN  JAL target address
- jalr_target  in  XLEN  raw JALR sum (rs1+imm), bit 0 not yet cleared
- trap_req  in  1  trap/exception redirect request
- trap_vector  in  XLEN  trap handler address
- pc  out  XLEN  current PC (register)
- pc_plus4  out  XLEN  pc + 4, combinational, wraps modulo 2^XLEN
- redirect  out  1  registered; 1 for one cycle after any non-sequential PC load
- misalign  out  1  registered; 1 for one cycle when a misaligned target was rejected
- misalign_addr  out  XLEN  registered; the rejected target address

## Operation
- States: RUN, FAULT. Reset state is RUN.
- Candidate target T:
  - sel=00: pc_plus4
  - sel=01: br_target
  - sel=10: jal_target
  - sel=11: {jalr_target[XLEN-1:1],1'b0}
- Misaligned condition bad = (sel≠00) and T[log2(IALIGN)-1:0] ≠ 0.
  - IALIGN=4: checks bits [1:0].
  - IALIGN=2: checks bit 0, so JALR can never fault.
- RUN, priority per clock edge, highest first:
  1. rst: pc←RESET_VECTOR; redirect, misalign←0; misalign_addr←0; state←RUN.
  2. trap_req: pc←trap_vector; redirect←1; misalign←0. Overrides stall and sel.
  3. stall: pc holds; redirect←0; misalign←0.
  4. bad: pc holds; misalign←1; misalign_addr←T; redirect←0; state←FAULT.
  5. else: pc←T; redirect←(sel≠00); misalign←0.
- FAULT, lasts exactly one cycle:
  - pc←trap_vector; redirect←1; misalign←0; state←RUN.
  - stall, sel and trap_req are ignored.
  - rst still has priority.
- misalign_addr holds its value until the next fault or reset.
- trap_vector is loaded without an alignment check.
- pc_plus4 carry out of bit XLEN-1 is discarded: 0xFFFF_FFFC+4 = 0.

## Timing
- Next-PC path is combinational from sel/targets to the pc register D input.
- Load latency: 1 cycle from inputs sampled to pc visible.
- redirect and misalign are asserted in the cycle the new pc (or the held pc) becomes visible. Each is at most a 1-cycle pulse per event.
- Misaligned branch, end to end:
  - edge N: fault detected, pc held, misalign=1.
  - edge N+1: pc=trap_vector, redirect=1.
- Reset asserted mid-FAULT: the FAULT exit is aborted, pc=RESET_VECTOR, no redirect pulse.
- Reset values: pc=RESET_VECTOR; redirect=0; misalign=0; misalign_addr=0.
- Back-to-back redirects (trap then branch) produce consecutive redirect pulses.

## Test plan
- Reset then free run, RESET_VECTOR=0x100, sel=00, 3 cycles -> pc 0x100, 0x104, 0x108, 0x10C; redirect stays 0.
- JALR bit clear: pc=0x200, sel=11, jalr_target=0x3001 -> next pc=0x3000, redirect=1 for one cycle, misalign=0.
- Stall vs trap: stall=1 with sel=01 and br_target=0x400 -> pc holds for 2 cycles. Then stall=1 and trap_req=1 with trap_vector=0x80 -> pc=0x80, redirect=1.
- Misaligned branch, IALIGN=4, pc=0x500, sel=01, br_target=0x602, trap_vector=0x40:
  - cycle 1: pc=0x500, misalign=1, misalign_addr=0x602.
  - cycle 2: pc=0x40, redirect=1, misalign=0.
  - Repeat with IALIGN=2: pc=0x602, no fault.
- Wrap-around: pc=0xFFFF_FFFC, sel=00 -> pc=0x0000_0000, redirect=0.
- Reset during FAULT: trigger a fault, assert rst on the next edge -> pc=RESET_VECTOR, redirect=0, misalign=0, state=RUN.
